// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, and feeds the IF/ID output
// register, with a one-entry skid for responses that land while the output is stalled.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instruction_out,
  output logic [31:0]                pc_current_out,
  output logic [31:0]                pc_next_out,
  output logic                       fetch_valid
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        consume;

  assign pc_inc  = pc + 32'd4;
  assign consume = fetch_valid && !stall;

  assign imem.imem_req  = (state == S_FETCH) && !reset;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_FETCH;
      pc              <= RESET_PC;
      skid_instr      <= '0;
      skid_pc         <= '0;
      fetch_valid     <= 1'b0;
      instruction_out <= BUBBLE_INSTR;
      pc_current_out  <= RESET_PC;
      pc_next_out     <= RESET_PC + 32'd4;
    end else if (redirect) begin
      pc              <= redirect_pc & ~32'd3;
      skid_instr      <= '0;
      skid_pc         <= '0;
      fetch_valid     <= 1'b0;
      instruction_out <= BUBBLE_INSTR;
      // An old-PC request already granted must still have its response swallowed.
      unique case (state)
        S_FETCH:   state <= imem.imem_gnt    ? S_DISCARD : S_FETCH;
        S_WAIT:    state <= imem.imem_rvalid ? S_FETCH   : S_DISCARD;
        S_HOLD:    state <= S_FETCH;
        S_DISCARD: state <= imem.imem_rvalid ? S_FETCH   : S_DISCARD;
        default:   state <= S_FETCH;
      endcase
    end else begin
      // Default: a consumed output empties unless a load below overrides it.
      if (consume) begin
        fetch_valid     <= 1'b0;
        instruction_out <= BUBBLE_INSTR;
      end
      unique case (state)
        S_FETCH: begin
          if (imem.imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            pc <= pc_inc;
            if (!fetch_valid || !stall) begin
              instruction_out <= imem.imem_rdata;
              pc_current_out  <= pc;
              pc_next_out     <= pc_inc;
              fetch_valid     <= 1'b1;
              state           <= S_FETCH;
            end else begin
              skid_instr <= imem.imem_rdata;
              skid_pc    <= pc;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instruction_out <= skid_instr;
            pc_current_out  <= skid_pc;
            pc_next_out     <= skid_pc + 32'd4;
            fetch_valid     <= 1'b1;
            state           <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem.imem_rvalid) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the bench plays the instruction memory by hand.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_out;
  logic [31:0] pc_current_out;
  logic [31:0] pc_next_out;
  logic        fetch_valid;

  int unsigned checks;
  int unsigned errors;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .BUBBLE_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem            (bus),
    .instruction_out (instruction_out),
    .pc_current_out  (pc_current_out),
    .pc_next_out     (pc_next_out),
    .fetch_valid     (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant the pending request, then return one response the following cycle.
  task automatic fetch_one(input logic [31:0] data);
    bus.imem_gnt    = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b want 0", bus.imem_req);
    end
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", fetch_valid);
    end
    checks++;
    if (instruction_out !== 32'h13) begin
      errors++; $display("FAIL reset_instr got %h want 00000013", instruction_out);
    end
    checks++;
    if (pc_current_out !== 32'h0 || pc_next_out !== 32'h4) begin
      errors++; $display("FAIL reset_pc got %h/%h want 00000000/00000004", pc_current_out, pc_next_out);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) * 32'd4;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin
        errors++; $display("FAIL seq_req[%0d] got req=%0b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, a);
      end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b0 || fetch_valid !== 1'b0 || instruction_out !== 32'h13) begin
        errors++; $display("FAIL seq_wait[%0d] got req=%0b valid=%0b instr=%h want 0/0/00000013", i, bus.imem_req, fetch_valid, instruction_out);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hA000 | a;
      tick();
      bus.imem_rvalid = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || instruction_out !== (32'hA000 | a) || pc_current_out !== a || pc_next_out !== a + 32'd4) begin
        errors++; $display("FAIL seq_load[%0d] got v=%0b instr=%h pc=%h next=%h want 1/%h/%h/%h", i, fetch_valid, instruction_out, pc_current_out, pc_next_out, 32'hA000 | a, a, a + 32'd4);
      end
    end
  endtask

  task automatic test_stall_skid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_one(32'hA000);
    fetch_one(32'hA004);
    stall = 1'b1;
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA008;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || fetch_valid !== 1'b1 || instruction_out !== 32'hA004 || pc_current_out !== 32'h4) begin
      errors++; $display("FAIL skid_hold got req=%0b v=%0b instr=%h pc=%h want 0/1/0000a004/00000004", bus.imem_req, fetch_valid, instruction_out, pc_current_out);
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b0 || instruction_out !== 32'hA004 || pc_next_out !== 32'h8) begin
      errors++; $display("FAIL skid_hold2 got req=%0b instr=%h next=%h want 0/0000a004/00000008", bus.imem_req, instruction_out, pc_next_out);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || instruction_out !== 32'hA008 || pc_current_out !== 32'h8 || pc_next_out !== 32'hC) begin
      errors++; $display("FAIL skid_drain got v=%0b instr=%h pc=%h next=%h want 1/0000a008/00000008/0000000c", fetch_valid, instruction_out, pc_current_out, pc_next_out);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      errors++; $display("FAIL skid_next_req got req=%0b addr=%h want 1/0000000c", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'h100;
    tick();
    redirect = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h13 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_wait got v=%0b instr=%h req=%0b want 0/00000013/0", fetch_valid, instruction_out, bus.imem_req);
    end
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h13) begin
      errors++; $display("FAIL redir_drop got v=%0b instr=%h want 0/00000013", fetch_valid, instruction_out);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_addr got req=%0b addr=%h want 1/00000100", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    fetch_one(32'h1234);
    checks++;
    if (fetch_valid !== 1'b1 || instruction_out !== 32'h1234 || pc_current_out !== 32'h100) begin
      errors++; $display("FAIL rs_load got v=%0b instr=%h pc=%h want 1/00001234/00000100", fetch_valid, instruction_out, pc_current_out);
    end
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h13) begin
      errors++; $display("FAIL rs_flush got v=%0b instr=%h want 0/00000013", fetch_valid, instruction_out);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++; $display("FAIL rs_addr got req=%0b addr=%h want 1/00000200", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_align got %h want fffffffc", bus.imem_addr);
    end
    fetch_one(32'hBEEF);
    checks++;
    if (instruction_out !== 32'hBEEF || pc_current_out !== 32'hFFFF_FFFC || pc_next_out !== 32'h0) begin
      errors++; $display("FAIL wrap_load got instr=%h pc=%h next=%h want 0000beef/fffffffc/00000000", instruction_out, pc_current_out, pc_next_out);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next got req=%0b addr=%h want 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_no_grant_and_reset();
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
        errors++; $display("FAIL nogrant[%0d] got req=%0b addr=%h want 1/00000000", i, bus.imem_req, bus.imem_addr);
      end
    end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait got req=%0b v=%0b want 0/0", bus.imem_req, fetch_valid);
    end
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h5555;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h13 || pc_current_out !== 32'h0) begin
      errors++; $display("FAIL stale_rvalid got v=%0b instr=%h pc=%h want 0/00000013/00000000", fetch_valid, instruction_out, pc_current_out);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL stale_req got req=%0b addr=%h want 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_no_grant_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
